password_lock_sequencer: RTL
============================

Name: password_lock_sequencer

Overview:
Top-level controller for the serial password lock. Sequences keypad digit entry into a 4-digit entry buffer and runs the compare against the stored user password and the fixed admin password. Owns the error counter, the lockdown flag, the unlock hold timer, and user-password re-programming. Sits between the debounced keypad front end and the lock/indicator LEDs.

Parameters:
ADMIN_PASSWORD_0, 0, admin digit 0 (4-bit value)
ADMIN_PASSWORD_1, 0, admin digit 1
ADMIN_PASSWORD_2, 0, admin digit 2
ADMIN_PASSWORD_3, 0, admin digit 3
MAX_ERRORS, 3, consecutive failures that set lockdown; legal range 1..3
TIMEOUT_CYCLES, 1000, idle cycles that abort a partial entry; must be >= 2
UNLOCK_HOLD_CYCLES, 500, cycles unlock stays asserted; must be >= 1

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  digit value 0..15
key_clear  in  1  one-cycle strobe: abort entry / relock
set_req  in  1  request password programming; honoured only while unlocked
digit_index  out  2  index of the next digit to be written
unlock  out  1  lock open
error_pulse  out  1  one-cycle pulse on failed compare
lockdown  out  1  lockdown flag
set_done  out  1  one-cycle pulse when new password committed
err_count  out  2  consecutive failure count
state_dbg  out  3  encoded FSM state, for debug

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high.
- States: S_IDLE=0, S_ENTER=1, S_CHECK=2, S_UNLOCKED=3, S_SET=4.
- Reset: state S_IDLE. User password = 0,0,0,0. Entry buffer, staging buffer, index, timers, err_count = 0. unlock, error_pulse, lockdown, set_done = 0. RST overrides every other input in that cycle.
- key_clear has priority over key_valid in the same cycle.
- S_IDLE:
  - key_valid: write entry[0], index=1, go to S_ENTER.
  - key_clear and set_req: ignored.
- S_ENTER:
  - key_valid: write entry[index], increment index. The 4th digit (index 3) goes to S_CHECK next cycle, index=0.
  - key_clear, or TIMEOUT_CYCLES consecutive cycles without key_valid: go to S_IDLE, index=0, err_count unchanged, no error_pulse.
  - The timeout counter reloads on every accepted digit.
- S_CHECK (exactly one cycle; key_valid dropped, not buffered):
  - Entry == admin digits: go to S_UNLOCKED, err_count=0, lockdown=0. Admin wins even if the entry also matches the user password.
  - Else entry == user password and lockdown=0: go to S_UNLOCKED, err_count=0.
  - Else: error_pulse=1 for one cycle and err_count saturates at MAX_ERRORS. When the new count == MAX_ERRORS, lockdown=1 in the same cycle. Go to S_IDLE.
  - While lockdown=1, only the admin digits unlock; a user match counts as a failure.
- Compare latency: the 4th key_valid at cycle N, CHECK at N+1, unlock=1 (or error_pulse=1) visible at N+2.
- S_UNLOCKED:
  - unlock=1. The hold counter loads UNLOCK_HOLD_CYCLES on entry.
  - On expiry: go to S_IDLE, unlock=0.
  - key_clear: go to S_IDLE next cycle.
  - set_req (without key_clear): go to S_SET, index=0, unlock=0.
  - key_valid: ignored.
- S_SET:
  - key_valid writes staging[index]. After the 4th digit, staging is copied to the user password in one cycle, set_done pulses 1 cycle, go to S_IDLE.
  - key_clear or timeout: abort, go to S_IDLE, user password unchanged.
- digit_index is the live index register and wraps 3->0 only on completion or abort.
- err_count does not decrement except on a successful unlock (clears to 0).
- lockdown is cleared only by an admin match or by RST.

Test Plan:
- RST, then key_valid digits 0,0,0,0 -> unlock=1 exactly 2 cycles after the 4th strobe, held 500 cycles, then 0. err_count=0.
- Params admin=9,8,7,6, user=0000. Enter 1,2,3,4 three times -> error_pulse each time, err_count 1,2,3, lockdown=1 after the 3rd. Then enter 0,0,0,0 -> error_pulse, still locked. Then enter 9,8,7,6 -> unlock=1, lockdown=0, err_count=0.
- Unlock, then set_req, then digits 5,5,1,2 -> set_done pulse, state S_IDLE. Entering 0000 fails. Entering 5512 unlocks.
- Enter 2 digits, then idle 1000 cycles -> S_IDLE, no error_pulse, err_count unchanged. Repeat with key_clear and key_valid in the same cycle after 1 digit -> S_IDLE, the digit is not written.
- In S_SET after 2 digits, assert key_clear -> S_IDLE, old password still unlocks, set_done never asserted.
- Assert RST mid-S_SET and during lockdown -> all outputs 0, password 0000, err_count 0 on the next cycle.

Source files
------------

// File: rtl/password_lock_sequencer.sv
// Serial password lock controller: sequences keypad digits into a 4-digit entry,
// compares against admin/user passwords, tracks failures/lockdown, holds unlock and reprograms.
module password_lock_sequencer #(
    parameter logic [3:0]  ADMIN_PASSWORD_0   = 4'd0,
    parameter logic [3:0]  ADMIN_PASSWORD_1   = 4'd0,
    parameter logic [3:0]  ADMIN_PASSWORD_2   = 4'd0,
    parameter logic [3:0]  ADMIN_PASSWORD_3   = 4'd0,
    parameter int unsigned MAX_ERRORS         = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 1000,
    parameter int unsigned UNLOCK_HOLD_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       set_req,
    output logic [1:0] digit_index,
    output logic       unlock,
    output logic       error_pulse,
    output logic       lockdown,
    output logic       set_done,
    output logic [1:0] err_count,
    output logic [2:0] state_dbg
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HoldW  = $clog2(UNLOCK_HOLD_CYCLES + 1);

    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [HoldW-1:0]  HoldLoad    = HoldW'(UNLOCK_HOLD_CYCLES);
    localparam logic [HoldW-1:0]  HoldOne     = HoldW'(1);
    localparam logic [1:0]        MaxErr      = 2'(MAX_ERRORS);

    // Digit i of a password lives in element [i].
    localparam logic [3:0][3:0] AdminPw = {ADMIN_PASSWORD_3, ADMIN_PASSWORD_2,
                                           ADMIN_PASSWORD_1, ADMIN_PASSWORD_0};

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StEnter    = 3'd1,
        StCheck    = 3'd2,
        StUnlocked = 3'd3,
        StSet      = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   entry_q, entry_d;
    logic [3:0][3:0]   staging_q, staging_d;
    logic [3:0][3:0]   user_pw_q, user_pw_d;
    logic [1:0]        err_q, err_d;
    logic              lockdown_q, lockdown_d;
    logic              error_pulse_q, error_pulse_d;
    logic              set_done_q, set_done_d;
    logic [TimerW-1:0] idle_q, idle_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic              admin_match;
    logic              user_match;
    logic [1:0]        err_fail;
    logic              timed_out;

    assign admin_match = (entry_q == AdminPw);
    assign user_match  = (entry_q == user_pw_q);
    assign err_fail    = (err_q >= MaxErr) ? MaxErr : err_q + 2'd1;
    assign timed_out   = (idle_q == TimeoutLast);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            entry_q       <= '0;
            staging_q     <= '0;
            user_pw_q     <= '0;
            err_q         <= 2'd0;
            lockdown_q    <= 1'b0;
            error_pulse_q <= 1'b0;
            set_done_q    <= 1'b0;
            idle_q        <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            entry_q       <= entry_d;
            staging_q     <= staging_d;
            user_pw_q     <= user_pw_d;
            err_q         <= err_d;
            lockdown_q    <= lockdown_d;
            error_pulse_q <= error_pulse_d;
            set_done_q    <= set_done_d;
            idle_q        <= idle_d;
            hold_q        <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        entry_d       = entry_q;
        staging_d     = staging_q;
        user_pw_d     = user_pw_q;
        err_d         = err_q;
        lockdown_d    = lockdown_q;
        error_pulse_d = 1'b0;
        set_done_d    = 1'b0;
        idle_d        = idle_q;
        hold_d        = hold_q;

        unique case (state_q)
            StIdle: begin
                // key_clear outranks key_valid, so a simultaneous strobe starts nothing.
                if (key_valid && !key_clear) begin
                    entry_d[0] = key_digit;
                    idx_d      = 2'd1;
                    idle_d     = '0;
                    state_d    = StEnter;
                end
            end

            StEnter: begin
                if (key_clear) begin
                    idx_d   = 2'd0;
                    idle_d  = '0;
                    state_d = StIdle;
                end else if (key_valid) begin
                    entry_d[idx_q] = key_digit;
                    idle_d         = '0;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (timed_out) begin
                    idx_d   = 2'd0;
                    idle_d  = '0;
                    state_d = StIdle;
                end else begin
                    idle_d = idle_q + TimerW'(1);
                end
            end

            StCheck: begin
                if (admin_match) begin
                    err_d      = 2'd0;
                    lockdown_d = 1'b0;
                    hold_d     = HoldLoad;
                    state_d    = StUnlocked;
                end else if (user_match && !lockdown_q) begin
                    err_d   = 2'd0;
                    hold_d  = HoldLoad;
                    state_d = StUnlocked;
                end else begin
                    error_pulse_d = 1'b1;
                    err_d         = err_fail;
                    if (err_fail == MaxErr) begin
                        lockdown_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end

            StUnlocked: begin
                if (key_clear) begin
                    state_d = StIdle;
                end else if (hold_q <= HoldOne) begin
                    state_d = StIdle;
                end else if (set_req) begin
                    idx_d   = 2'd0;
                    idle_d  = '0;
                    state_d = StSet;
                end else begin
                    hold_d = hold_q - HoldOne;
                end
            end

            StSet: begin
                if (key_clear) begin
                    idx_d   = 2'd0;
                    idle_d  = '0;
                    state_d = StIdle;
                end else if (key_valid) begin
                    staging_d[idx_q] = key_digit;
                    idle_d           = '0;
                    if (idx_q == 2'd3) begin
                        // Commit on the final digit so the new password is live on return to idle.
                        user_pw_d    = staging_q;
                        user_pw_d[3] = key_digit;
                        set_done_d   = 1'b1;
                        idx_d        = 2'd0;
                        state_d      = StIdle;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (timed_out) begin
                    idx_d   = 2'd0;
                    idle_d  = '0;
                    state_d = StIdle;
                end else begin
                    idle_d = idle_q + TimerW'(1);
                end
            end

            default: begin
                idx_d   = 2'd0;
                state_d = StIdle;
            end
        endcase
    end

    assign digit_index = idx_q;
    assign unlock      = (state_q == StUnlocked);
    assign error_pulse = error_pulse_q;
    assign lockdown    = lockdown_q;
    assign set_done    = set_done_q;
    assign err_count   = err_q;
    assign state_dbg   = state_q;

endmodule
